// File: rtl/hart_sched_pkg.sv
// Shared constants, hart state encoding and the per-hart state transition
// function for the fine-grained multithreading issue scheduler.
package hart_sched_pkg;

    localparam int HART_NUM_DEF  = 4;
    localparam int HART_ID_W_DEF = 2;
    localparam int BOOT_HART_DEF = 0;

    typedef enum logic [1:0] {
        HART_IDLE    = 2'b00,
        HART_ACTIVE  = 2'b01,
        HART_SUSPEND = 2'b10
    } hart_state_e;

    // The unused encoding 2'b11 is treated as IDLE.
    function automatic hart_state_e decode_state(input logic [1:0] raw);
        case (raw)
            2'b01:   return HART_ACTIVE;
            2'b10:   return HART_SUSPEND;
            default: return HART_IDLE;
        endcase
    endfunction

    // Priority: kill > suspend > resume > start.
    function automatic hart_state_e next_state(input hart_state_e cur,
                                               input logic        kill_hit,
                                               input logic        susp_hit,
                                               input logic        resume_hit,
                                               input logic        start_hit);
        if (kill_hit)
            return HART_IDLE;
        if (susp_hit)
            return (cur == HART_ACTIVE) ? HART_SUSPEND : cur;
        if (resume_hit)
            return (cur == HART_SUSPEND) ? HART_ACTIVE : cur;
        if (start_hit)
            return (cur == HART_IDLE) ? HART_ACTIVE : cur;
        return cur;
    endfunction

endpackage

// File: rtl/hart_sched_rr_arb.sv
// Combinational rotate-priority arbiter: grants the first requester strictly
// after last_i (cyclically); last_i itself wins only if it is the sole requester.
module hart_rr_arb #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] gnt_id_o,
    output logic         gnt_vld_o
);

    logic [W-1:0] idx;

    // Walk from the farthest offset down so the nearest requester overwrites.
    always_comb begin
        idx       = '0;
        gnt_id_o  = last_i;
        gnt_vld_o = |req_i;
        for (int k = N; k >= 1; k--) begin
            idx = last_i + W'(k);
            if (req_i[idx])
                gnt_id_o = idx;
        end
    end

endmodule

// File: rtl/hart_sched.sv
// Issue scheduler ahead of IF/ID: tracks per-hart IDLE/ACTIVE/SUSPEND state
// and rotates fetch round-robin over the harts that will be ACTIVE next cycle.
module hart_sched
    import hart_sched_pkg::*;
#(
    parameter int HART_NUM  = HART_NUM_DEF,
    parameter int HART_ID_W = HART_ID_W_DEF,
    parameter int BOOT_HART = BOOT_HART_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 start_req,
    input  logic [HART_ID_W-1:0] start_id,
    input  logic                 kill_req,
    input  logic [HART_ID_W-1:0] kill_id,
    input  logic                 susp_req,
    input  logic [HART_ID_W-1:0] susp_id,
    input  logic                 resume_req,
    input  logic [HART_ID_W-1:0] resume_id,
    output logic [HART_ID_W-1:0] hart_id,
    output logic [HART_NUM-1:0]  hart_st,
    output logic                 issue_en,
    output logic                 all_idle
);

    logic [HART_NUM-1:0]  active_d;
    logic [HART_NUM-1:0]  idle_d;
    logic [HART_ID_W-1:0] sel;
    logic                 sel_vld;

    logic [HART_ID_W-1:0] hart_id_q,  hart_id_d;
    logic [HART_ID_W-1:0] rr_last_q,  rr_last_d;
    logic                 issue_en_q, issue_en_d;
    logic [HART_NUM-1:0]  hart_st_q;
    logic                 all_idle_q;

    genvar gi;
    generate
        for (gi = 0; gi < HART_NUM; gi++) begin : g_hart
            logic [1:0]  state_q;
            hart_state_e state_d;

            always_comb begin
                state_d = next_state(decode_state(state_q),
                                     kill_req   && (kill_id   == HART_ID_W'(gi)),
                                     susp_req   && (susp_id   == HART_ID_W'(gi)),
                                     resume_req && (resume_id == HART_ID_W'(gi)),
                                     start_req  && (start_id  == HART_ID_W'(gi)));
            end

            assign active_d[gi] = (state_d == HART_ACTIVE);
            assign idle_d[gi]   = (state_d == HART_IDLE);

            // State advances every edge; stall only freezes issue selection.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    state_q <= (gi == BOOT_HART) ? HART_ACTIVE : HART_IDLE;
                else
                    state_q <= state_d;
            end
        end
    endgenerate

    hart_rr_arb #(
        .N (HART_NUM),
        .W (HART_ID_W)
    ) u_arb (
        .req_i     (active_d),
        .last_i    (rr_last_q),
        .gnt_id_o  (sel),
        .gnt_vld_o (sel_vld)
    );

    always_comb begin
        hart_id_d  = hart_id_q;
        rr_last_d  = rr_last_q;
        issue_en_d = 1'b0;
        if (!stall) begin
            if (sel_vld) begin
                hart_id_d  = sel;
                rr_last_d  = sel;
                issue_en_d = 1'b1;
            end
        end else begin
            // A frozen hart killed or suspended during the stall stops issuing.
            issue_en_d = active_d[hart_id_q];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hart_id_q  <= HART_ID_W'(BOOT_HART);
            rr_last_q  <= HART_ID_W'(HART_NUM - 1);
            issue_en_q <= 1'b1;
            hart_st_q  <= HART_NUM'(1) << BOOT_HART;
            all_idle_q <= 1'b0;
        end else begin
            hart_id_q  <= hart_id_d;
            rr_last_q  <= rr_last_d;
            issue_en_q <= issue_en_d;
            hart_st_q  <= active_d;
            all_idle_q <= &idle_d;
        end
    end

    assign hart_id  = hart_id_q;
    assign hart_st  = hart_st_q;
    assign issue_en = issue_en_q;
    assign all_idle = all_idle_q;

endmodule

// File: tb/tb_hart_sched.sv
// Directed bench for hart_sched: hand-computed issue sequences, request
// priority, stall behaviour, all-idle and asynchronous reset.
module tb_hart_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stall = 1'b0;
    logic       start_req = 1'b0, kill_req = 1'b0, susp_req = 1'b0, resume_req = 1'b0;
    logic [1:0] start_id = '0, kill_id = '0, susp_id = '0, resume_id = '0;
    logic [1:0] hart_id;
    logic [3:0] hart_st;
    logic       issue_en;
    logic       all_idle;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hart_sched dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .start_req  (start_req),
        .start_id   (start_id),
        .kill_req   (kill_req),
        .kill_id    (kill_id),
        .susp_req   (susp_req),
        .susp_id    (susp_id),
        .resume_req (resume_req),
        .resume_id  (resume_id),
        .hart_id    (hart_id),
        .hart_st    (hart_st),
        .issue_en   (issue_en),
        .all_idle   (all_idle)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic chk_all(input string tag, input int id, input int en, input int st, input int idle);
        check_eq({tag, ".hart_id"},  32'(hart_id),  32'(id));
        check_eq({tag, ".issue_en"}, 32'(issue_en), 32'(en));
        check_eq({tag, ".hart_st"},  32'(hart_st),  32'(st));
        check_eq({tag, ".all_idle"}, 32'(all_idle), 32'(idle));
    endtask

    // One clock with the given requests (-1 = none); outputs sampled 1 ns after the edge.
    task automatic cyc(input int st, input int kl, input int sp, input int rs);
        start_req  = (st >= 0); start_id  = (st >= 0) ? st[1:0] : 2'd0;
        kill_req   = (kl >= 0); kill_id   = (kl >= 0) ? kl[1:0] : 2'd0;
        susp_req   = (sp >= 0); susp_id   = (sp >= 0) ? sp[1:0] : 2'd0;
        resume_req = (rs >= 0); resume_id = (rs >= 0) ? rs[1:0] : 2'd0;
        @(posedge clk);
        #1;
        start_req = 1'b0; kill_req = 1'b0; susp_req = 1'b0; resume_req = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b0;
        #3 chk_all("reset", 0, 1, 4'b0001, 0);
        #8 reset = 1'b1;

        // Only the boot hart active: it is reissued every cycle.
        for (int i = 0; i < 3; i++) begin
            cyc(-1, -1, -1, -1);
            chk_all("boot_only", 0, 1, 4'b0001, 0);
        end

        // Start hart 2: alternates 2,0,2,0.
        cyc(2, -1, -1, -1);
        chk_all("start2", 2, 1, 4'b0101, 0);
        cyc(-1, -1, -1, -1); check_eq("alt.0", 32'(hart_id), 0);
        cyc(-1, -1, -1, -1); check_eq("alt.2", 32'(hart_id), 2);
        cyc(-1, -1, -1, -1); check_eq("alt.0b", 32'(hart_id), 0);

        // Bring all four up, then check wrap-around rotation.
        cyc(1, -1, -1, -1); chk_all("start1", 1, 1, 4'b0111, 0);
        cyc(3, -1, -1, -1); chk_all("start3", 2, 1, 4'b1111, 0);
        cyc(-1, -1, -1, -1); check_eq("rot.3", 32'(hart_id), 3);
        cyc(-1, -1, -1, -1); check_eq("rot.0", 32'(hart_id), 0);
        cyc(-1, -1, -1, -1); check_eq("rot.1", 32'(hart_id), 1);

        // Suspend 2 while 1 issues: 3 follows, 2 skipped.
        cyc(-1, -1, 2, -1); chk_all("susp2", 3, 1, 4'b1011, 0);
        cyc(-1, -1, -1, -1); check_eq("skip.0", 32'(hart_id), 0);
        cyc(-1, -1, -1, -1); check_eq("skip.1", 32'(hart_id), 1);
        cyc(-1, -1, -1, 2); chk_all("resume2", 2, 1, 4'b1111, 0);

        // Kill beats suspend and resume on the same hart.
        cyc(-1, 1, 1, 1); chk_all("kill_prio", 3, 1, 4'b1101, 0);
        cyc(-1, 2, 3, -1); chk_all("kill2_susp3", 0, 1, 4'b0001, 0);
        cyc(-1, 3, -1, -1); chk_all("kill3", 0, 1, 4'b0001, 0);
        cyc(3, 0, -1, -1); chk_all("start3_kill0", 3, 1, 4'b1000, 0);

        // Harts 0,1 active, then stall.
        cyc(0, 3, -1, -1); chk_all("start0_kill3", 0, 1, 4'b0001, 0);
        cyc(1, -1, -1, -1); chk_all("start1b", 1, 1, 4'b0011, 0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(-1, -1, -1, -1);
            chk_all("stall", 1, 1, 4'b0011, 0);
        end
        cyc(-1, 1, -1, -1); chk_all("stall_kill", 1, 0, 4'b0001, 0);
        stall = 1'b0;
        cyc(-1, -1, -1, -1); chk_all("unstall", 0, 1, 4'b0001, 0);

        // Kill the last active hart.
        cyc(-1, 0, -1, -1); chk_all("kill_last", 0, 0, 4'b0000, 1);
        cyc(-1, -1, -1, 1); chk_all("resume_idle", 0, 0, 4'b0000, 1);
        cyc(-1, -1, 2, -1); chk_all("susp_idle", 0, 0, 4'b0000, 1);
        cyc(2, -1, -1, -1); chk_all("restart2", 2, 1, 4'b0100, 0);

        // Asynchronous reset between clock edges.
        #2 reset = 1'b0;
        #1 chk_all("async_rst", 0, 1, 4'b0001, 0);
        #3 reset = 1'b1;
        cyc(-1, -1, -1, -1); chk_all("post_rst", 0, 1, 4'b0001, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
